// File: rtl/uart_rx_if.sv
// Received-word handshake bundle between the UART receiver and its consumer.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            frame_err;
  logic            parity_err;
  logic            overrun;

  // Receiver side drives the word and flags, consumer drives ready.
  modport master (output rx_data, rx_valid, frame_err, parity_err, overrun,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, parity_err, overrun,
                  output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, glitch-rejecting start detect,
// mid-bit sampling off an oversampling tick, registered valid/ready output.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     baud_tick,
  input  logic     rx,
  input  logic     parity_en,
  input  logic     parity_odd,
  uart_rx_if.master rx_bus
);
  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [1:0]      sync_q;
  logic            armed_q, armed_d;
  logic            pen_q, pen_d, podd_q, podd_d;
  logic            perr_q, perr_d;
  logic            done, ferr, rx_s;

  logic [DBIT-1:0] data_q, data_d;
  logic            valid_q, valid_d, ferr_q, ferr_d, perr_o_q, perr_o_d, ovr_q, ovr_d;

  assign rx_s = sync_q[1];

  // Synchronise the asynchronous serial line; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  // Frame FSM and sampling counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      armed_q <= 1'b1;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state: counters move only on baud_tick; done marks the stop-bit sample.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    perr_d  = perr_q;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // armed_q blocks a held-low break from retriggering a frame.
        if (!rx_s && armed_q) begin
          state_d = START;
          s_d     = '0;
          pen_d   = parity_en;
          podd_d  = parity_odd;
          perr_d  = 1'b0;
        end
      end
      START: if (baud_tick) begin
        if (s_q == S_HALF) begin
          s_d     = '0;
          n_d     = '0;
          state_d = rx_s ? IDLE : DATA;
        end else s_d = s_q + SW'(1);
      end
      DATA: if (baud_tick) begin
        if (s_q == S_BIT) begin
          s_d  = '0;
          sh_d = {rx_s, sh_q[DBIT-1:1]};
          if (n_q == N_LAST) state_d = pen_q ? PARITY : STOP;
          else               n_d = n_q + NW'(1);
        end else s_d = s_q + SW'(1);
      end
      PARITY: if (baud_tick) begin
        if (s_q == S_BIT) begin
          s_d     = '0;
          perr_d  = (^{sh_q, rx_s}) ^ podd_q;
          state_d = STOP;
        end else s_d = s_q + SW'(1);
      end
      STOP: if (baud_tick) begin
        if (s_q == S_STOP) begin
          s_d     = '0;
          done    = 1'b1;
          ferr    = ~rx_s;
          state_d = IDLE;
        end else s_d = s_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Re-arm on any high level; a frame ending low (break/framing error) disarms.
    armed_d = rx_s ? 1'b1 : (done ? 1'b0 : armed_q);
  end

  // Output word and flags: load on completion, hold until accepted.
  always_comb begin
    data_d   = data_q;
    ferr_d   = ferr_q;
    perr_o_d = perr_o_q;
    valid_d  = valid_q & ~rx_bus.rx_ready;
    ovr_d    = 1'b0;
    if (done) begin
      data_d   = sh_q;
      ferr_d   = ferr;
      perr_o_d = perr_q;
      valid_d  = 1'b1;
      ovr_d    = valid_q & ~rx_bus.rx_ready;
    end
  end

  // Output registers; nothing downstream sees rx_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      perr_o_q <= perr_o_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.parity_err = perr_o_q;
  assign rx_bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: free-running baud tick, bit-banged serial frames.
module tb_uart_rx;
  localparam int DVSR     = 5;
  localparam int BIT_CLKS = 16 * DVSR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  int   tick_cnt = 0;

  int errors = 0;
  int checks = 0;

  // Observers sampled on the falling edge.
  int       vld_cnt = 0;
  int       cap_cnt = 0;
  int       ovr_cnt = 0;
  logic [7:0] cap_data = '0;
  logic     cap_ferr = 1'b0;
  logic     cap_perr = 1'b0;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_bus     (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt  <= (tick_cnt == DVSR - 1) ? 0 : tick_cnt + 1;
    baud_tick <= (tick_cnt == DVSR - 1);
  end

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) vld_cnt <= vld_cnt + 1;
    if (bus.overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
      cap_cnt  <= cap_cnt + 1;
      cap_data <= bus.rx_data;
      cap_ferr <= bus.frame_err;
      cap_perr <= bus.parity_err;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", bus.overrun); end
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0, c0;
    v0 = vld_cnt; c0 = cap_cnt;
    bus.rx_ready = 1'b1; parity_en = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", cap_cnt - c0); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", vld_cnt - v0); end
    checks++; if (cap_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", cap_data); end
    checks++; if ({cap_ferr, cap_perr} !== 2'b00) begin errors++; $display("FAIL basic_errs got=%b exp=00", {cap_ferr, cap_perr}); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vld_cnt;
    rx = 1'b0;
    repeat (4 * DVSR) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL glitch_valid got=%0d exp=%0d", vld_cnt, v0); end
    // A clean frame right after must still be received.
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    checks++; if (cap_data !== 8'h96) begin errors++; $display("FAIL glitch_recover got=%h exp=96", cap_data); end
  endtask

  task automatic test_frame_err();
    int c0;
    c0 = cap_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", cap_cnt - c0); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got=%h exp=3c", cap_data); end
    checks++; if (cap_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", cap_ferr); end
  endtask

  task automatic test_parity();
    parity_en = 1'b1; parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    checks++; if (cap_data !== 8'h07) begin errors++; $display("FAIL par_data0 got=%h exp=07", cap_data); end
    checks++; if ({cap_ferr, cap_perr} !== 2'b00) begin errors++; $display("FAIL par_ok got=%b exp=00", {cap_ferr, cap_perr}); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    checks++; if (cap_data !== 8'h07) begin errors++; $display("FAIL par_data1 got=%h exp=07", cap_data); end
    checks++; if ({cap_ferr, cap_perr} !== 2'b01) begin errors++; $display("FAIL par_bad got=%b exp=01", {cap_ferr, cap_perr}); end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    checks++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL ovr_first got=%b/%h exp=1/11", bus.rx_valid, bus.rx_data); end
    checks++; if (ovr_cnt !== o0) begin errors++; $display("FAIL ovr_none got=%0d exp=%0d", ovr_cnt, o0); end
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - o0); end
    checks++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL ovr_second got=%b/%h exp=1/22", bus.rx_valid, bus.rx_data); end
    bus.rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h22) begin errors++; $display("FAIL ovr_hold got=%h exp=22", bus.rx_data); end
  endtask

  task automatic test_mid_reset();
    rx = 1'b0;                          // start bit
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    repeat (BIT_CLKS / 2) @(negedge clk);  // middle of data bit 4
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    checks++; if ({bus.rx_valid, bus.frame_err, bus.parity_err, bus.overrun} !== 4'b0000) begin errors++; $display("FAIL mrst_flags got=%b exp=0000", {bus.rx_valid, bus.frame_err, bus.parity_err, bus.overrun}); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL mrst_data got=%h exp=00", bus.rx_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_discard got=%b exp=0", bus.rx_valid); end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if (cap_data !== 8'h5A) begin errors++; $display("FAIL mrst_next got=%h exp=5a", cap_data); end
    checks++; if ({cap_ferr, cap_perr} !== 2'b00) begin errors++; $display("FAIL mrst_errs got=%b exp=00", {cap_ferr, cap_perr}); end
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
